mul_div_unit: RTL
=================

// Module: mul_div_unit
// PURPOSE
//  Multi-cycle signed multiply/divide engine; the execute-side consumer of the mul/div ALU control
//  codes (ALUCtr 4'b1011 = mul, 4'b1100 = div). Holds the architectural HI/LO registers read by
//  mfhi/mflo. Stalls the single-cycle CPU through busy until the result is written.
// PARAMETERS
//  WIDTH  32  operand/HI/LO width; iteration count equals WIDTH
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      asynchronous, active-high reset
//  start      in   1      request; sampled only when state is IDLE or DONE
//  ALUCtr     in   4      operation code; only 4'b1011 (mul) and 4'b1100 (div) act
//  A          in   WIDTH  operand rs (multiplicand / dividend), two's complement
//  B          in   WIDTH  operand rt (multiplier / divisor), two's complement
//  busy       out  1      high while iterating; CPU holds PC and instruction while high
//  done       out  1      one-cycle pulse; HI/LO hold the new result in that cycle
//  divByZero  out  1      high together with done when the completed div had B == 0
//  HI         out  WIDTH  mul: product[2W-1:W]; div: remainder
//  LO         out  WIDTH  mul: product[W-1:0];  div: quotient
// BEHAVIOUR
//  Reset (async): state=IDLE, busy=0, done=0, divByZero=0, HI=0, LO=0, counter=0, internal regs=0.
//  States: IDLE, MUL, DIV, DONE. busy = (state==MUL || state==DIV); done = (state==DONE).
//  IDLE/DONE + start + ALUCtr==mul            -> MUL; latch |A|, |B|, signs; counter=0.
//  IDLE/DONE + start + ALUCtr==div, B!=0      -> DIV; latch |A|, |B|, signs; counter=0.
//  IDLE/DONE + start + ALUCtr==div, B==0      -> DONE next edge; HI=A, LO={WIDTH{1'b1}}, divByZero=1.
//  IDLE/DONE + start + other ALUCtr, or no start -> IDLE; HI/LO unchanged.
//  MUL: shift-add on magnitudes, one multiplier bit per cycle; DIV: restoring, one quotient bit/cycle.
//  counter==WIDTH-1 in MUL/DIV -> DONE; on that edge apply sign fix and write HI/LO.
//  Latency: start sampled at edge E0; busy high cycles 1..WIDTH; done (and HI/LO valid) cycle WIDTH+1.
//  Sign rules: product negated iff sign(A)^sign(B) (full 2W-bit negate); quotient negated iff
//   sign(A)^sign(B); remainder takes sign(A) (truncating division, |rem| < |B|).
//  Edge values: most-negative / -1 -> LO=most-negative (wraps), HI=0; most-negative*most-negative ->
//   HI=2^(W-2), LO=0; magnitude of most-negative handled as unsigned W-bit 2^(W-1).
//  start while busy: ignored; operands/ALUCtr changes while busy: ignored (latched at start).
//  Back-to-back: start in DONE cycle is accepted; done falls, busy rises next cycle.
//  divByZero cleared whenever state leaves DONE; HI/LO change only on the edge entering DONE.
//  Reset mid-operation: immediate abort to reset values above; no partial result ever reaches HI/LO.
// STRUCTURE
//  Shared package: ALU control codes (ALU_MUL=4'b1011, ALU_DIV=4'b1100, plus existing add/sub/etc.
//   codes for the ALU), mul_div state encoding (2-bit IDLE/MUL/DIV/DONE).
//  Sub-module muldiv_signfix: combinational abs() of inputs and conditional negation of results;
//   FSM, counter, shift/accumulate registers and HI/LO stay in mul_div_unit.
// TESTING
//  1. mul A=7, B=-3 -> busy 32 cycles, done at cycle 33, HI=32'hFFFFFFFF, LO=32'hFFFFFFEB.
//  2. div A=-7, B=2 -> LO=32'hFFFFFFFD (-3), HI=32'hFFFFFFFF (-1), divByZero=0.
//  3. div A=5, B=0 -> done at cycle 1, no busy, HI=5, LO=32'hFFFFFFFF, divByZero=1.
//  4. mul 32'h80000000*32'h80000000 -> HI=32'h40000000, LO=0; div 32'h80000000/-1 -> LO=32'h80000000, HI=0.
//  5. start with ALUCtr=4'b0010 -> stays IDLE, busy=0, HI/LO unchanged; start pulses mid-mul ignored;
//     start in DONE cycle with new div 100/7 -> LO=14, HI=2 at cycle 33 after that edge.
//  6. reset asserted at iteration 10 of mul 3*4 -> busy,done,HI,LO = 0 asynchronously; restart 3*4 -> LO=12.

Source files
------------

// File: rtl/mul_div_unit_pkg.sv
// Shared ALU control codes and mul/div FSM state encoding.
// Imported by the execute-side datapath and the mul/div engine.
package mul_div_unit_pkg;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_NOR = 4'b1000;
   localparam logic [3:0] ALU_MUL = 4'b1011;
   localparam logic [3:0] ALU_DIV = 4'b1100;

   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_MUL  = 2'b01;
   localparam logic [1:0] ST_DIV  = 2'b10;
   localparam logic [1:0] ST_DONE = 2'b11;

endpackage

// File: rtl/mul_div_unit_signfix.sv
// Operand magnitudes and result sign correction for mul_div_unit.
// The most-negative input maps to the unsigned magnitude 2^(WIDTH-1).
module muldiv_signfix #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               neg_q,
   input  logic               neg_r,
   input  logic [2*WIDTH-1:0] prod,
   input  logic [WIDTH-1:0]   quot,
   input  logic [WIDTH-1:0]   rem,
   output logic [WIDTH-1:0]   abs_a,
   output logic [WIDTH-1:0]   abs_b,
   output logic [2*WIDTH-1:0] prod_fix,
   output logic [WIDTH-1:0]   quot_fix,
   output logic [WIDTH-1:0]   rem_fix
);

   assign abs_a    = a[WIDTH-1] ? -a : a;
   assign abs_b    = b[WIDTH-1] ? -b : b;
   assign prod_fix = neg_q ? -prod : prod;
   assign quot_fix = neg_q ? -quot : quot;
   assign rem_fix  = neg_r ? -rem : rem;

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle signed multiply / restoring divide engine holding HI/LO.
// One bit per cycle on magnitudes; sign fix applied on the edge into DONE.
module mul_div_unit
   import mul_div_unit_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       ALUCtr,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic             divByZero,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO
);

   localparam int CW = $clog2(WIDTH);

   logic [1:0]       state;
   logic [CW-1:0]    counter;
   logic [WIDTH-1:0] opb;
   logic [WIDTH-1:0] acc_hi;
   logic [WIDTH-1:0] acc_lo;
   logic             neg_q;
   logic             neg_r;

   logic [WIDTH-1:0]   abs_a;
   logic [WIDTH-1:0]   abs_b;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quot_fix;
   logic [WIDTH-1:0]   rem_fix;

   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_nxt;
   logic [WIDTH:0]     div_sh;
   logic [WIDTH:0]     div_diff;
   logic               div_ge;
   logic [WIDTH-1:0]   rem_nxt;
   logic [WIDTH-1:0]   quo_nxt;

   logic is_mul;
   logic div_go;
   logic div_zero;
   logic last;

   assign busy = (state == ST_MUL) || (state == ST_DIV);
   assign done = (state == ST_DONE);

   assign is_mul   = (ALUCtr == ALU_MUL);
   assign div_go   = (ALUCtr == ALU_DIV) && (B != '0);
   assign div_zero = (ALUCtr == ALU_DIV) && (B == '0);
   assign last     = (counter == CW'(WIDTH - 1));

   // Multiplier sits in acc_lo and shifts out as product bits shift in.
   assign mul_sum = {1'b0, acc_hi}
                  + (acc_lo[0] ? {1'b0, opb} : '0);
   assign mul_nxt = {mul_sum, acc_lo[WIDTH-1:1]};

   // Dividend sits in acc_lo and shifts into the remainder.
   assign div_sh   = {acc_hi, acc_lo[WIDTH-1]};
   assign div_diff = div_sh - {1'b0, opb};
   assign div_ge   = ~div_diff[WIDTH];
   assign rem_nxt  = div_ge ? div_diff[WIDTH-1:0]
                            : div_sh[WIDTH-1:0];
   assign quo_nxt  = {acc_lo[WIDTH-2:0], div_ge};

   muldiv_signfix #(.WIDTH(WIDTH)) u_signfix (
      .a        (A),
      .b        (B),
      .neg_q    (neg_q),
      .neg_r    (neg_r),
      .prod     (mul_nxt),
      .quot     (quo_nxt),
      .rem      (rem_nxt),
      .abs_a    (abs_a),
      .abs_b    (abs_b),
      .prod_fix (prod_fix),
      .quot_fix (quot_fix),
      .rem_fix  (rem_fix)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         counter   <= '0;
         opb       <= '0;
         acc_hi    <= '0;
         acc_lo    <= '0;
         neg_q     <= 1'b0;
         neg_r     <= 1'b0;
         divByZero <= 1'b0;
         HI        <= '0;
         LO        <= '0;
      end else begin
         case (state)
            ST_MUL: begin
               {acc_hi, acc_lo} <= mul_nxt;
               counter <= counter + CW'(1);
               if (last) begin
                  state <= ST_DONE;
                  HI    <= prod_fix[2*WIDTH-1:WIDTH];
                  LO    <= prod_fix[WIDTH-1:0];
               end
            end
            ST_DIV: begin
               acc_hi  <= rem_nxt;
               acc_lo  <= quo_nxt;
               counter <= counter + CW'(1);
               if (last) begin
                  state <= ST_DONE;
                  HI    <= rem_fix;
                  LO    <= quot_fix;
               end
            end
            default: begin
               state     <= ST_IDLE;
               divByZero <= 1'b0;
               if (start) begin
                  unique case (1'b1)
                     is_mul: begin
                        state   <= ST_MUL;
                        counter <= '0;
                        acc_hi  <= '0;
                        acc_lo  <= abs_b;
                        opb     <= abs_a;
                        neg_q   <= A[WIDTH-1] ^ B[WIDTH-1];
                        neg_r   <= A[WIDTH-1];
                     end
                     div_go: begin
                        state   <= ST_DIV;
                        counter <= '0;
                        acc_hi  <= '0;
                        acc_lo  <= abs_a;
                        opb     <= abs_b;
                        neg_q   <= A[WIDTH-1] ^ B[WIDTH-1];
                        neg_r   <= A[WIDTH-1];
                     end
                     div_zero: begin
                        state     <= ST_DONE;
                        divByZero <= 1'b1;
                        HI        <= A;
                        LO        <= '1;
                     end
                     default: ;
                  endcase
               end
            end
         endcase
      end
   end

endmodule
